// File: rtl/rambus_apb_master.sv
// Fabric-side APB3 initiator: turns one command handshake into one APB transfer,
// honouring PREADY wait states and aborting hung transfers after a wait-state budget.
module rambus_apb_master #(
    parameter int ADDR_WIDTH     = 14,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  CmdValid,
    output logic                  CmdReady,
    input  logic                  CmdWrnRd,
    input  logic [ADDR_WIDTH-1:0] CmdAddress,
    input  logic [DATA_WIDTH-1:0] CmdDataIn,
    output logic                  RspValid,
    output logic [DATA_WIDTH-1:0] RspDataOut,
    output logic                  RspError,
    output logic                  RspTimeout,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
    localparam bit TIMEOUT_ON = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t                  state_reg,      state_next;
    logic [CNT_W-1:0]        waitCnt_reg,    waitCnt_next;
    logic                    cmdReady_reg,   cmdReady_next;
    logic                    psel_reg,       psel_next;
    logic                    penable_reg,    penable_next;
    logic                    pwrite_reg,     pwrite_next;
    logic [ADDR_WIDTH-1:0]   paddr_reg,      paddr_next;
    logic [DATA_WIDTH-1:0]   pwdata_reg,     pwdata_next;
    logic                    rspValid_reg,   rspValid_next;
    logic [DATA_WIDTH-1:0]   rspData_reg,    rspData_next;
    logic                    rspError_reg,   rspError_next;
    logic                    rspTimeout_reg, rspTimeout_next;
    logic [DATA_WIDTH-1:0]   rdCapture;

    // Writes report zero data, so read data is masked by the latched direction.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_WIDTH; gi++) begin : gen_rd_mask
            assign rdCapture[gi] = PRDATA[gi] & ~pwrite_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            waitCnt_reg    <= '0;
            cmdReady_reg   <= 1'b0;
            psel_reg       <= 1'b0;
            penable_reg    <= 1'b0;
            pwrite_reg     <= 1'b0;
            paddr_reg      <= '0;
            pwdata_reg     <= '0;
            rspValid_reg   <= 1'b0;
            rspData_reg    <= '0;
            rspError_reg   <= 1'b0;
            rspTimeout_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            waitCnt_reg    <= waitCnt_next;
            cmdReady_reg   <= cmdReady_next;
            psel_reg       <= psel_next;
            penable_reg    <= penable_next;
            pwrite_reg     <= pwrite_next;
            paddr_reg      <= paddr_next;
            pwdata_reg     <= pwdata_next;
            rspValid_reg   <= rspValid_next;
            rspData_reg    <= rspData_next;
            rspError_reg   <= rspError_next;
            rspTimeout_reg <= rspTimeout_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        waitCnt_next    = waitCnt_reg;
        cmdReady_next   = cmdReady_reg;
        psel_next       = psel_reg;
        penable_next    = penable_reg;
        pwrite_next     = pwrite_reg;
        paddr_next      = paddr_reg;
        pwdata_next     = pwdata_reg;
        rspValid_next   = 1'b0;
        rspData_next    = rspData_reg;
        rspError_next   = rspError_reg;
        rspTimeout_next = rspTimeout_reg;

        case (state_reg)
            IDLE: begin
                cmdReady_next = 1'b1;
                psel_next     = 1'b0;
                penable_next  = 1'b0;
                // CmdReady is registered, so the first edge after reset only raises it.
                if (cmdReady_reg && CmdValid) begin
                    pwrite_next   = CmdWrnRd;
                    paddr_next    = CmdAddress;
                    pwdata_next   = CmdDataIn;
                    waitCnt_next  = '0;
                    cmdReady_next = 1'b0;
                    psel_next     = 1'b1;
                    state_next    = SETUP;
                end
            end
            SETUP: begin
                psel_next    = 1'b1;
                penable_next = 1'b1;
                state_next   = ACCESS;
            end
            ACCESS: begin
                if (PREADY) begin
                    rspData_next    = rdCapture;
                    rspError_next   = PSLVERR;
                    rspTimeout_next = 1'b0;
                    rspValid_next   = 1'b1;
                    psel_next       = 1'b0;
                    penable_next    = 1'b0;
                    state_next      = RESP;
                end else if (TIMEOUT_ON && (waitCnt_reg == CNT_LIMIT)) begin
                    rspData_next    = '0;
                    rspError_next   = 1'b1;
                    rspTimeout_next = 1'b1;
                    rspValid_next   = 1'b1;
                    psel_next       = 1'b0;
                    penable_next    = 1'b0;
                    state_next      = RESP;
                end else if (waitCnt_reg != CNT_MAX) begin
                    waitCnt_next = waitCnt_reg + 1'b1;
                end
            end
            RESP: begin
                cmdReady_next = 1'b1;
                state_next    = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign CmdReady   = cmdReady_reg;
    assign PSEL       = psel_reg;
    assign PENABLE    = penable_reg;
    assign PWRITE     = pwrite_reg;
    assign PADDR      = paddr_reg;
    assign PWDATA     = pwdata_reg;
    assign RspValid   = rspValid_reg;
    assign RspDataOut = rspData_reg;
    assign RspError   = rspError_reg;
    assign RspTimeout = rspTimeout_reg;

endmodule

// File: tb/tb_rambus_apb_master.sv
// Bench for rambus_apb_master: table of commands with a scripted APB responder and a
// scoreboard that checks every response, latency and per-transfer PSEL/PENABLE counts.
module tb_rambus_apb_master;

    localparam int TO = 8;

    logic        clk;
    logic        rst;
    logic        CmdValid;
    logic        CmdReady;
    logic        CmdWrnRd;
    logic [13:0] CmdAddress;
    logic [31:0] CmdDataIn;
    logic        RspValid;
    logic [31:0] RspDataOut;
    logic        RspError;
    logic        RspTimeout;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [13:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    rambus_apb_master #(
        .ADDR_WIDTH(14),
        .DATA_WIDTH(32),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .CmdValid(CmdValid), .CmdReady(CmdReady), .CmdWrnRd(CmdWrnRd),
        .CmdAddress(CmdAddress), .CmdDataIn(CmdDataIn),
        .RspValid(RspValid), .RspDataOut(RspDataOut), .RspError(RspError),
        .RspTimeout(RspTimeout),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    typedef struct {
        bit          wr;
        logic [13:0] addr;
        logic [31:0] wdata;
        int          waits;
        logic [31:0] prdata;
        bit          slverr;
        logic [31:0] expData;
        bit          expErr;
        bit          expTo;
    } vec_t;

    typedef struct {
        int          idx;
        bit          wr;
        logic [13:0] addr;
        logic [31:0] wdata;
        logic [31:0] expData;
        bit          expErr;
        bit          expTo;
        int          lat;
        int          acceptCyc;
    } sb_t;

    vec_t vecs[11];
    sb_t  q[$];

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          lastAccept = 0;
    int          pselCnt = 0;
    int          penCnt = 0;
    int          acc = 0;
    int          respWaits = 0;
    logic [31:0] respData = '0;
    logic        respErr = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    // Scripted responder: PREADY rises on ACCESS cycle number respWaits (0-based).
    always @(negedge clk) begin
        if (PSEL && PENABLE) begin
            if (acc == respWaits) begin
                PREADY  = 1'b1;
                PRDATA  = respData;
                PSLVERR = respErr;
            end else begin
                PREADY  = 1'b0;
                PRDATA  = 32'hBAD0BAD0;
                PSLVERR = 1'b0;
            end
            acc++;
        end else begin
            PREADY  = 1'b0;
            PRDATA  = 32'hBAD0BAD0;
            PSLVERR = 1'b0;
            acc     = 0;
        end
    end

    // Response monitor and APB stability checks.
    always @(negedge clk) begin
        sb_t e;
        if (rst) begin
            pselCnt = 0;
            penCnt  = 0;
        end else begin
            if (PSEL) pselCnt++;
            if (PENABLE) penCnt++;
            if (PSEL && PENABLE && q.size() > 0) begin
                chk("access_paddr", 32'(PADDR), 32'(q[0].addr));
                chk("access_pwrite", 32'(PWRITE), 32'(q[0].wr));
                chk("access_pwdata", PWDATA, q[0].wdata);
            end
            if (RspValid) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: got RspValid=1, required 0 (no command pending)");
                end else begin
                    e = q.pop_front();
                    $display("txn %0d wr=%0d addr=%h data=%h err=%0d to=%0d lat=%0d",
                             e.idx, e.wr, e.addr, RspDataOut, RspError, RspTimeout,
                             cyc - e.acceptCyc);
                    chk("rsp_data", RspDataOut, e.expData);
                    chk("rsp_error", 32'(RspError), 32'(e.expErr));
                    chk("rsp_timeout", 32'(RspTimeout), 32'(e.expTo));
                    chk("rsp_latency", 32'(cyc - e.acceptCyc), 32'(e.lat));
                    chk("psel_cycles", 32'(pselCnt), 32'(e.lat));
                    chk("penable_cycles", 32'(penCnt), 32'(e.lat - 1));
                    chk("rsp_bus_idle", 32'({PSEL, PENABLE, CmdReady}), 32'(0));
                end
                pselCnt = 0;
                penCnt  = 0;
            end
        end
    end

    // Called at a negedge; returns one negedge after the accepting edge.
    task automatic sendCmd(input int idx, input bit holdValid);
        int  guard;
        sb_t e;
        CmdValid   = 1'b1;
        CmdWrnRd   = vecs[idx].wr;
        CmdAddress = vecs[idx].addr;
        CmdDataIn  = vecs[idx].wdata;
        guard = 0;
        while (CmdReady !== 1'b1 && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 64) begin
            checks++;
            errors++;
            $display("FAIL accept idx=%0d: got CmdReady=%b, required 1", idx, CmdReady);
            CmdValid = 1'b0;
            return;
        end
        respWaits   = vecs[idx].waits;
        respData    = vecs[idx].prdata;
        respErr     = vecs[idx].slverr;
        e.idx       = idx;
        e.wr        = vecs[idx].wr;
        e.addr      = vecs[idx].addr;
        e.wdata     = vecs[idx].wdata;
        e.expData   = vecs[idx].expData;
        e.expErr    = vecs[idx].expErr;
        e.expTo     = vecs[idx].expTo;
        e.lat       = vecs[idx].expTo ? TO + 2 : vecs[idx].waits + 2;
        e.acceptCyc = cyc + 1;
        q.push_back(e);
        lastAccept  = cyc + 1;
        @(negedge clk);
        if (!holdValid) CmdValid = 1'b0;
    endtask

    task automatic waitIdle();
        int guard;
        guard = 0;
        while (q.size() != 0 && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 64) begin
            checks++;
            errors++;
            $display("FAIL rsp_wait: got %0d pending responses, required 0", q.size());
            q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        int prevAccept;
        //          wr    addr      wdata          waits prdata        err   expData       eErr  eTo
        vecs[0]  = '{1'b1, 14'h0010, 32'hA5A51234, 0,  32'hDEADBEEF, 1'b0, 32'h00000000, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 14'h3FFF, 32'h00000000, 3,  32'hCAFEF00D, 1'b0, 32'hCAFEF00D, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 14'h0123, 32'h0BADC0DE, 0,  32'h12345678, 1'b1, 32'h12345678, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 14'h2000, 32'h87654321, 2,  32'h11112222, 1'b1, 32'h00000000, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 14'h0042, 32'h00000000, 99, 32'hFFFFFFFF, 1'b0, 32'h00000000, 1'b1, 1'b1};
        vecs[5]  = '{1'b0, 14'h0043, 32'h00000000, 8,  32'h55AA55AA, 1'b0, 32'h55AA55AA, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 14'h0044, 32'h00000000, 7,  32'h0F0F0F0F, 1'b0, 32'h0F0F0F0F, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 14'h0001, 32'h00000000, 0,  32'h11111111, 1'b0, 32'h11111111, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 14'h0002, 32'h22222222, 0,  32'h99999999, 1'b0, 32'h00000000, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 14'h0003, 32'h00000000, 0,  32'h33333333, 1'b0, 32'h33333333, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 14'h0004, 32'h44444444, 0,  32'h88888888, 1'b0, 32'h00000000, 1'b0, 1'b0};

        rst        = 1'b1;
        CmdValid   = 1'b0;
        CmdWrnRd   = 1'b0;
        CmdAddress = '0;
        CmdDataIn  = '0;
        repeat (3) @(negedge clk);
        chk("reset_cmdready", 32'(CmdReady), 0);
        chk("reset_psel", 32'(PSEL), 0);
        chk("reset_penable", 32'(PENABLE), 0);
        chk("reset_pwrite", 32'(PWRITE), 0);
        chk("reset_paddr", 32'(PADDR), 0);
        chk("reset_pwdata", PWDATA, 0);
        chk("reset_rspvalid", 32'(RspValid), 0);
        chk("reset_rspdata", RspDataOut, 0);
        chk("reset_rsperror", 32'(RspError), 0);
        chk("reset_rsptimeout", 32'(RspTimeout), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_cmdready", 32'(CmdReady), 1);

        // Single transfers: write, waited read, slave errors, timeout and its boundaries.
        for (int i = 0; i < 7; i++) begin
            sendCmd(i, 1'b0);
            waitIdle();
            if (i == 1) begin
                repeat (3) @(negedge clk);
                chk("hold_rspdata", RspDataOut, 32'hCAFEF00D);
                chk("hold_rsperror", 32'(RspError), 0);
            end
        end

        // Back-to-back with CmdValid held high throughout.
        for (int i = 7; i < 11; i++) begin
            prevAccept = lastAccept;
            sendCmd(i, i != 10);
            if (i > 7) chk("b2b_spacing", 32'(lastAccept - prevAccept), 4);
        end
        waitIdle();

        // Reset while the responder stalls in ACCESS.
        sendCmd(4, 1'b0);
        repeat (2) @(negedge clk);
        chk("pre_reset_in_access", 32'({PSEL, PENABLE}), 32'(3));
        rst = 1'b1;
        q.delete();
        @(negedge clk);
        chk("midreset_bus", 32'({PSEL, PENABLE, RspValid, CmdReady}), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("midreset_cmdready", 32'(CmdReady), 1);
        repeat (15) @(negedge clk);
        chk("midreset_no_rsp", 32'(RspValid), 0);

        // Recovery transfer after the aborted one.
        sendCmd(2, 1'b0);
        waitIdle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
